max_stream_reduce: RTL and testbench
====================================

MAX_STREAM_REDUCE -- requirements
Module: max_stream_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits (unsigned).
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum beats per frame (2..256).
REQ-003 SHALL have parameter IDX_W, default 8, index/count width; IDX_W SHALL satisfy 2^IDX_W >= MAX_LEN.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: upstream sample valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have port in_data, input, WIDTH: unsigned sample.
REQ-009 SHALL have port in_last, input, 1: sample closes the current frame.
REQ-010 SHALL have port out_valid, output, 1: frame result valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port out_max, output, WIDTH: largest sample of the frame.
REQ-013 SHALL have port out_idx, output, IDX_W: zero-based beat index of out_max within the frame.
REQ-014 SHALL have port out_count, output, IDX_W+1: number of beats in the frame.
REQ-015 SHALL have port out_forced, output, 1: frame closed by MAX_LEN, not by in_last.

Function
REQ-016 SHALL treat a beat as accepted when in_valid && in_ready at a rising clk edge.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational), so a new beat may be accepted in the same cycle the held result is consumed.
REQ-018 SHALL implement states IDLE (no frame open), ACCUM (frame open), HOLD (result held, out_valid=1).
REQ-019 IDLE: an accepted beat SHALL load run_max=in_data, run_idx=0, beat count=1 and go to ACCUM, or go straight to HOLD when in_last=1 (single-beat frame).
REQ-020 ACCUM: an accepted beat with in_data strictly greater than run_max SHALL replace run_max and set run_idx to the current beat index; equal values SHALL NOT replace (earliest maximum wins).
REQ-021 The comparison SHALL be a full WIDTH-bit unsigned magnitude compare; no wrap or sign interpretation.
REQ-022 An accepted beat with in_last=1, or the beat that makes the count equal MAX_LEN, SHALL close the frame; the result registers SHALL load on that edge and out_valid SHALL rise in the following cycle (latency 1 cycle from closing beat to out_valid).
REQ-023 out_forced SHALL be 1 only when the frame closed at MAX_LEN with in_last=0; in_last=1 on the MAX_LEN-th beat SHALL give out_forced=0.
REQ-024 Beats arriving after a forced close SHALL start a new frame at index 0.
REQ-025 HOLD: out_max, out_idx, out_count, out_forced SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 HOLD with out_ready=1: out_valid SHALL fall next cycle unless a beat is accepted in the same cycle, in which case that beat SHALL be processed exactly as in IDLE (REQ-019), including immediate return to HOLD for a single-beat frame.
REQ-027 While an open frame is in ACCUM, out_valid SHALL be 0; the block SHALL hold at most one completed result.
REQ-028 in_valid=0 cycles inside a frame SHALL leave all frame state unchanged.
REQ-029 Output data ports SHALL be register outputs; only in_ready is combinational.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, out_valid=0, out_max=0, out_idx=0, out_count=0, out_forced=0, and clear run_max, run_idx, beat count.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or held result; no result SHALL be emitted for it.
REQ-032 After rst_n deasserts, in_ready SHALL be 1 and the next accepted beat SHALL be index 0 of a new frame.

Verification
REQ-033 Frame 3,9,2,9,5 (last on 5), out_ready=1 -> one cycle after last beat: out_max=9, out_idx=1, out_count=5, out_forced=0.
REQ-034 MAX_LEN=16, 20 beats 0..19 no in_last -> first result max=15, idx=15, count=16, forced=1; second frame (beats 16..19, last on 19) max=19, idx=3, count=4, forced=0.
REQ-035 Single beat 0xFF with in_last, out_ready=0 for 5 cycles -> out_valid held, out_max=0xFF, idx=0, count=1, in_ready=0 throughout; in_ready=1 when out_ready rises.
REQ-036 Back-to-back single-beat frames 7,4 with out_ready=1 and in_valid continuous -> in_ready stays 1, results 7 then 4 on consecutive cycles, no beat lost.
REQ-037 Frame 10,20 then rst_n=0 before last beat -> out_valid stays 0; after release, frame 1 (last) -> out_max=1, idx=0, count=1.
REQ-038 Randomized in_valid/out_ready with reference model -> every result matches earliest-max, index, count; no beat dropped or duplicated.

Source files
------------

// File: rtl/max_stream_reduce.sv
// Streaming frame reducer: reports the earliest maximum sample of each frame,
// its beat index, the beat count and whether the frame was cut at MAX_LEN.
module max_stream_reduce #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_forced
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LEN);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   run_max, run_max_nxt, cand_max;
    logic [IDX_W-1:0]   run_idx, run_idx_nxt, cand_idx;
    logic [IDX_W:0]     cnt, cnt_nxt, cand_cnt;
    logic               accept, close;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Candidate frame state if the current beat is accepted; any state other
    // than ACCUM treats the beat as index 0 of a fresh frame.
    always_comb begin
        cand_max = in_data;
        cand_idx = '0;
        cand_cnt = CNT_ONE;
        if (state == ACCUM) begin
            cand_cnt = cnt + CNT_ONE;
            cand_max = run_max;
            cand_idx = run_idx;
            if (in_data > run_max) begin
                cand_max = in_data;
                cand_idx = cnt[IDX_W-1:0];
            end
        end
        close = accept && (in_last || (cand_cnt == MAX_CNT));
    end

    always_comb begin
        state_nxt   = state;
        run_max_nxt = run_max;
        run_idx_nxt = run_idx;
        cnt_nxt     = cnt;
        if (accept) begin
            if (close) begin
                state_nxt   = HOLD;
                run_max_nxt = '0;
                run_idx_nxt = '0;
                cnt_nxt     = '0;
            end else begin
                state_nxt   = ACCUM;
                run_max_nxt = cand_max;
                run_idx_nxt = cand_idx;
                cnt_nxt     = cand_cnt;
            end
        end else if (state == HOLD && out_ready) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run_max    <= '0;
            run_idx    <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_max    <= '0;
            out_idx    <= '0;
            out_count  <= '0;
            out_forced <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_max   <= run_max_nxt;
            run_idx   <= run_idx_nxt;
            cnt       <= cnt_nxt;
            out_valid <= (state_nxt == HOLD);
            // Result registers only move on a closing beat, so they stay frozen in HOLD.
            if (close) begin
                out_max    <= cand_max;
                out_idx    <= cand_idx;
                out_count  <= cand_cnt;
                out_forced <= !in_last;
            end
        end
    end

endmodule

// File: tb/tb_max_stream_reduce.sv
// Directed table vectors, hand-written multi-cycle sequences and a randomized
// scoreboard run for max_stream_reduce (WIDTH=8, MAX_LEN=16, IDX_W=8).
module tb_max_stream_reduce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_max;
    logic [7:0] out_idx;
    logic [8:0] out_count;
    logic       out_forced;

    int checks = 0;
    int errors = 0;

    max_stream_reduce #(.WIDTH(8), .MAX_LEN(16), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
        .out_idx(out_idx), .out_count(out_count), .out_forced(out_forced)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r;
        logic       ev;
        logic       eir;
        logic [7:0] emax;
        logic [7:0] eidx;
        logic [8:0] ecnt;
        logic       ef;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic ev, input logic eir, input logic dchk,
                       input logic [7:0] emax, input logic [7:0] eidx,
                       input logic [8:0] ecnt, input logic ef);
        checks++;
        if (out_valid !== ev || in_ready !== eir ||
            (dchk && (out_max !== emax || out_idx !== eidx || out_count !== ecnt || out_forced !== ef))) begin
            errors++;
            $display("FAIL %s: got v=%0b rdy=%0b max=%0d idx=%0d cnt=%0d forced=%0b; want v=%0b rdy=%0b max=%0d idx=%0d cnt=%0d forced=%0b",
                     nm, out_valid, in_ready, out_max, out_idx, out_count, out_forced,
                     ev, eir, emax, eidx, ecnt, ef);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model for the randomized run
    int m_open, m_max, m_idx, m_cnt, m_outv;
    int r_max, r_idx, r_cnt, r_f;

    initial begin
        // Frame 3,9,2,9,5; back-to-back singles 7,4; held 0xFF under backpressure
        tbl[0]  = '{1, 8'd3,   0, 1, 0, 1, 8'd0,   8'd0, 9'd0, 0};
        tbl[1]  = '{1, 8'd9,   0, 1, 0, 1, 8'd0,   8'd0, 9'd0, 0};
        tbl[2]  = '{1, 8'd2,   0, 1, 0, 1, 8'd0,   8'd0, 9'd0, 0};
        tbl[3]  = '{1, 8'd9,   0, 1, 0, 1, 8'd0,   8'd0, 9'd0, 0};
        tbl[4]  = '{1, 8'd5,   1, 1, 0, 1, 8'd0,   8'd0, 9'd0, 0};
        tbl[5]  = '{0, 8'd0,   0, 1, 1, 1, 8'd9,   8'd1, 9'd5, 0};
        tbl[6]  = '{0, 8'd0,   0, 1, 0, 1, 8'd9,   8'd1, 9'd5, 0};
        tbl[7]  = '{1, 8'd7,   1, 1, 0, 1, 8'd9,   8'd1, 9'd5, 0};
        tbl[8]  = '{1, 8'd4,   1, 1, 1, 1, 8'd7,   8'd0, 9'd1, 0};
        tbl[9]  = '{0, 8'd0,   0, 1, 1, 1, 8'd4,   8'd0, 9'd1, 0};
        tbl[10] = '{0, 8'd0,   0, 1, 0, 1, 8'd4,   8'd0, 9'd1, 0};
        tbl[11] = '{1, 8'hFF,  1, 0, 0, 1, 8'd4,   8'd0, 9'd1, 0};
        for (int i = 12; i < 17; i++)
            tbl[i] = '{1, 8'h11, 1, 0, 1, 0, 8'hFF, 8'd0, 9'd1, 0};
        tbl[17] = '{0, 8'd0,   0, 1, 1, 1, 8'hFF,  8'd0, 9'd1, 0};
        tbl[18] = '{0, 8'd0,   0, 1, 0, 1, 8'hFF,  8'd0, 9'd1, 0};

        do_reset();
        @(negedge clk);
        chk("reset_state", 0, 1, 1, 8'd0, 8'd0, 9'd0, 0);
        adv();

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk($sformatf("table_row%0d", i), tbl[i].ev, tbl[i].eir, 1,
                tbl[i].emax, tbl[i].eidx, tbl[i].ecnt, tbl[i].ef);
            adv();
        end

        // 20 beats 0..19, closed by MAX_LEN then by in_last on beat 19
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(i), (i == 19), 1);
            if (i == 16) chk("forced_close", 1, 1, 1, 8'd15, 8'd15, 9'd16, 1);
            if (i == 17) chk("after_forced_valid_drop", 0, 1, 0, 8'd0, 8'd0, 9'd0, 0);
            adv();
        end
        drive(0, 8'd0, 0, 1);
        chk("second_frame", 1, 1, 1, 8'd19, 8'd3, 9'd4, 0);
        adv();

        // in_last on the 16th beat is not a forced close; ties keep earliest index
        for (int i = 0; i < 16; i++) begin
            drive(1, (i == 2 || i == 9) ? 8'd200 : 8'd200 - 8'(i) - 8'd1, (i == 15), 1);
            adv();
        end
        drive(0, 8'd0, 0, 1);
        chk("last_at_max_len", 1, 1, 1, 8'd200, 8'd2, 9'd16, 0);
        adv();

        // Unsigned compare across the top bit
        drive(1, 8'h7F, 0, 1); adv();
        drive(1, 8'h80, 0, 1); adv();
        drive(0, 8'h00, 0, 1); adv();
        drive(1, 8'h01, 1, 1); adv();
        drive(0, 8'd0, 0, 1);
        chk("unsigned_compare_gap", 1, 1, 1, 8'h80, 8'd1, 9'd3, 0);
        adv();

        // Reset mid-frame discards the partial frame
        drive(1, 8'd10, 0, 1); adv();
        drive(1, 8'd20, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_midframe", 0, 1, 1, 8'd0, 8'd0, 9'd0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 8'd0, 0, 1);
        chk("after_reset_idle", 0, 1, 1, 8'd0, 8'd0, 9'd0, 0);
        adv();
        drive(1, 8'd1, 1, 1); adv();
        drive(0, 8'd0, 0, 1);
        chk("after_reset_frame", 1, 1, 1, 8'd1, 8'd0, 9'd1, 0);
        adv();

        // Randomized handshakes against a reference model
        do_reset();
        m_open = 0; m_max = 0; m_idx = 0; m_cnt = 0; m_outv = 0;
        r_max = 0; r_idx = 0; r_cnt = 0; r_f = 0;
        for (int n = 0; n < 400; n++) begin
            logic v, l, r, eir;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            l = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 2) != 0);
            drive(v, d, l, r);
            eir = (m_outv == 0) || r;
            chk($sformatf("random_cycle%0d", n), m_outv[0], eir, m_outv[0],
                8'(r_max), 8'(r_idx), 9'(r_cnt), r_f[0]);
            if (m_outv != 0 && r) m_outv = 0;
            if (v && eir) begin
                if (m_open == 0) begin
                    m_max = d; m_idx = 0; m_cnt = 1;
                end else begin
                    if (int'(d) > m_max) begin
                        m_max = d; m_idx = m_cnt;
                    end
                    m_cnt++;
                end
                if (l || m_cnt == 16) begin
                    r_max = m_max; r_idx = m_idx; r_cnt = m_cnt; r_f = l ? 0 : 1;
                    m_outv = 1; m_open = 0;
                end else begin
                    m_open = 1;
                end
            end
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
